pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_call_stack.sv | 43 ++++
 rtl/pc_unit.sv | 158 +++++++++++++++
 tb/tb_pc_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM states and next-PC source select.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_HOLD  = 3'd0,
    SRC_START = 3'd1,
    SRC_RET   = 3'd2,
    SRC_CALL  = 3'd3,
    SRC_ABS   = 3'd4,
    SRC_REL   = 3'd5,
    SRC_INC   = 3'd6
  } pc_src_t;

endpackage

// File: rtl/pc_call_stack.sv
// Return-address LIFO; clear and reset empty it, callers never push and pop together.
module pc_call_stack #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  // Storage is rounded up to a power of two so the entry count can index it directly.
  logic [PC_W-1:0]  mem [0:(1<<CNT_W)-1];
  logic [CNT_W-1:0] count;

  assign full     = (count == CNT_W'(STACK_DEPTH));
  assign empty    = (count == '0);
  assign top_data = mem[count - CNT_W'(1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (push && !full)
      count <= count + CNT_W'(1);
    else if (pop && !empty)
      count <= count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear)
      mem[count] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with launch FSM, branches and optional call stack (macro PC_CALL_STACK_EN).
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int REL_W       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchAbsEn,
  input  logic             BranchRelEn,
  input  logic             ALU_flag,
  input  logic [REL_W-1:0] RelTarget,
  input  logic [PC_W-1:0]  AbsTarget,
  input  logic             CallEn,
  input  logic             RetEn,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             StackErr
);

  pc_state_t       state, state_next;
  pc_src_t         pc_src;
  logic [PC_W-1:0] pc_next, pc_inc, rel_ext;
  logic            stack_clear, stack_push, stack_pop, err_set;

  assign pc_inc  = ProgCtr + PC_W'(1);
  assign rel_ext = PC_W'($signed(RelTarget));

`ifdef PC_CALL_STACK_EN
  logic [PC_W-1:0] stack_top;
  logic            stack_full, stack_empty;

  pc_call_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (Clk),
    .rst       (Reset),
    .clear     (stack_clear),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (pc_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );
`else
  logic unused_stack;
  assign unused_stack = RetEn ^ stack_clear ^ stack_push ^ stack_pop ^ err_set;
`endif

  // Start always restarts through ARMED; Halt and Stall only matter while running.
  always_comb begin
    state_next  = state;
    pc_src      = SRC_HOLD;
    stack_clear = 1'b0;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    err_set     = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_next  = ST_ARMED;
          stack_clear = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!Start) begin
          state_next = ST_RUN;
          pc_src     = SRC_START;
        end
      end
      ST_RUN: begin
        if (Start) begin
          state_next  = ST_ARMED;
          stack_clear = 1'b1;
        end else if (Halt) begin
          state_next = ST_HALT;
        end else if (!Stall) begin
`ifdef PC_CALL_STACK_EN
          if (RetEn) begin
            if (!stack_empty) begin
              pc_src    = SRC_RET;
              stack_pop = 1'b1;
            end else begin
              pc_src  = SRC_INC;
              err_set = 1'b1;
            end
          end else if (CallEn) begin
            if (!stack_full) begin
              pc_src     = SRC_CALL;
              stack_push = 1'b1;
            end else begin
              pc_src  = SRC_INC;
              err_set = 1'b1;
            end
          end else
`endif
          if (CallEn || BranchAbsEn)
            pc_src = SRC_ABS;
          else if (BranchRelEn && !ALU_flag)
            pc_src = SRC_REL;
          else
            pc_src = SRC_INC;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_next = ProgCtr;
    case (pc_src)
      SRC_START:         pc_next = StartAddr;
`ifdef PC_CALL_STACK_EN
      SRC_RET:           pc_next = stack_top;
`endif
      SRC_CALL, SRC_ABS: pc_next = AbsTarget;
      SRC_REL:           pc_next = ProgCtr + rel_ext;
      SRC_INC:           pc_next = pc_inc;
      default:           pc_next = ProgCtr;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      ProgCtr <= '0;
    end else begin
      state   <= state_next;
      ProgCtr <= pc_next;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      StackErr <= 1'b0;
    else if (stack_clear)
      StackErr <= 1'b0;
    else if (err_set)
      StackErr <= 1'b1;
  end
`else
  assign StackErr = 1'b0;
`endif

  assign Running = (state == ST_RUN);
  assign Done    = (state == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_unit;

  localparam int PC_W  = 10;
  localparam int REL_W = 8;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << PC_W;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start, Stall, Halt, BranchAbsEn, BranchRelEn, ALU_flag, CallEn, RetEn;
  logic [PC_W-1:0]  StartAddr, AbsTarget;
  logic [REL_W-1:0] RelTarget;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running, Done, StackErr;

  int vecCount = 0;
  int errCount = 0;

  // Reference model: mode 0 idle, 1 armed, 2 run, 3 halt
  int mMode, mPc, mErr;
  int mStack[$];

  pc_unit #(.PC_W(PC_W), .REL_W(REL_W), .STACK_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .Halt(Halt), .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn), .ALU_flag(ALU_flag),
    .RelTarget(RelTarget), .AbsTarget(AbsTarget), .CallEn(CallEn), .RetEn(RetEn),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int wrapPc(input int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  task automatic modelReset();
    mMode = 0; mPc = 0; mErr = 0;
    mStack.delete();
  endtask

  task automatic enterArmed();
    mMode = 1; mErr = 0;
    mStack.delete();
  endtask

  task automatic modelClock();
    int rel;
    rel = $signed(RelTarget);
    case (mMode)
      0, 3: if (Start) enterArmed();
      1: if (!Start) begin mMode = 2; mPc = int'(StartAddr); end
      default: begin
        if (Start) enterArmed();
        else if (Halt) mMode = 3;
        else if (!Stall) begin
`ifdef PC_CALL_STACK_EN
          if (RetEn) begin
            if (mStack.size() > 0) mPc = mStack.pop_back();
            else begin mPc = wrapPc(mPc + 1); mErr = 1; end
          end else if (CallEn) begin
            if (mStack.size() < DEPTH) begin
              mStack.push_back(wrapPc(mPc + 1));
              mPc = int'(AbsTarget);
            end else begin mPc = wrapPc(mPc + 1); mErr = 1; end
          end else
`endif
          if (CallEn || BranchAbsEn) mPc = int'(AbsTarget);
          else if (BranchRelEn && !ALU_flag) mPc = wrapPc(mPc + rel);
          else mPc = wrapPc(mPc + 1);
        end
      end
    endcase
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_pc"},   ProgCtr,  mPc);
    checkOutput({tag, "_run"},  Running,  (mMode == 2) ? 1 : 0);
    checkOutput({tag, "_done"}, Done,     (mMode == 3) ? 1 : 0);
    checkOutput({tag, "_err"},  StackErr, mErr);
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge Clk);
    modelClock();
    @(negedge Clk);
    compareAll(tag);
  endtask

  task automatic clearInputs();
    Start = 0; Stall = 0; Halt = 0; BranchAbsEn = 0; BranchRelEn = 0;
    ALU_flag = 0; CallEn = 0; RetEn = 0;
    StartAddr = '0; AbsTarget = '0; RelTarget = '0;
  endtask

  task automatic launch(input int addr);
    clearInputs();
    Start = 1;
    applyStimulus("arm");
    Start = 0;
    StartAddr = PC_W'(addr);
    applyStimulus("launch");
  endtask

  // Reset pulse placed between clock edges, checked before the next edge arrives
  task automatic midCycleReset(input string tag);
    #2 Reset = 1;
    #1 modelReset();
    compareAll(tag);
    checkOutput({tag, "_pc0"}, ProgCtr, 0);
    #1 Reset = 0;
  endtask

  initial begin
    clearInputs();
    Reset = 1;
    modelReset();
    @(negedge Clk);
    compareAll("reset");
    checkOutput("reset_pc0", ProgCtr, 0);
    Reset = 0;

    Start = 1;
    applyStimulus("arm1");
    applyStimulus("arm2");
    checkOutput("armed_pc", ProgCtr, 0);
    Start = 0;
    StartAddr = 10'd100;
    applyStimulus("go");
    checkOutput("start_pc", ProgCtr, 100);
    checkOutput("start_run", Running, 1);
    applyStimulus("inc");
    checkOutput("inc_pc", ProgCtr, 101);

    launch(17);
    BranchRelEn = 1; RelTarget = 8'hFB; ALU_flag = 0;
    applyStimulus("rel_taken");
    checkOutput("rel_taken_pc", ProgCtr, 12);
    launch(17);
    BranchRelEn = 1; RelTarget = 8'hFB; ALU_flag = 1;
    applyStimulus("rel_not");
    checkOutput("rel_not_pc", ProgCtr, 18);

    launch(1023);
    applyStimulus("wrap_up");
    checkOutput("wrap_up_pc", ProgCtr, 0);
    launch(2);
    BranchRelEn = 1; RelTarget = 8'hFC;
    applyStimulus("wrap_dn");
    checkOutput("wrap_dn_pc", ProgCtr, 1022);

    launch(20);
    CallEn = 1; AbsTarget = 10'd50;
    applyStimulus("call");
    checkOutput("call_pc", ProgCtr, 50);
    CallEn = 0; RetEn = 1;
    applyStimulus("ret");
`ifdef PC_CALL_STACK_EN
    checkOutput("ret_pc", ProgCtr, 21);
`else
    checkOutput("ret_pc", ProgCtr, 51);
`endif

    launch(0);
    for (int i = 0; i < 5; i++) begin
      CallEn = 1; AbsTarget = PC_W'(200 + 10 * i);
      applyStimulus("nest");
    end
`ifdef PC_CALL_STACK_EN
    checkOutput("nest_pc", ProgCtr, 231);
    checkOutput("nest_err", StackErr, 1);
`else
    checkOutput("nest_pc", ProgCtr, 240);
`endif

    launch(30);
    Stall = 1; CallEn = 1; AbsTarget = 10'd99;
    repeat (3) applyStimulus("stall");
    checkOutput("stall_pc", ProgCtr, 30);
    clearInputs();
    Halt = 1;
    applyStimulus("halt");
    checkOutput("halt_done", Done, 1);
    Halt = 0; BranchAbsEn = 1; AbsTarget = 10'd7;
    repeat (2) applyStimulus("halted");
    checkOutput("halted_pc", ProgCtr, 30);
    BranchAbsEn = 0;

    launch(40);
    CallEn = 1; AbsTarget = 10'd300;
    applyStimulus("precall");
    midCycleReset("async");
    checkOutput("async_run", Running, 0);
    launch(60);
    RetEn = 1;
    applyStimulus("ret_empty");
`ifdef PC_CALL_STACK_EN
    checkOutput("ret_empty_err", StackErr, 1);
`else
    checkOutput("ret_empty_err", StackErr, 0);
`endif

    for (int n = 0; n < 400; n++) begin
      Start       = ($urandom_range(15) == 0);
      Halt        = ($urandom_range(31) == 0);
      Stall       = ($urandom_range(7) == 0);
      RetEn       = ($urandom_range(5) == 0);
      CallEn      = ($urandom_range(5) == 0);
      BranchAbsEn = ($urandom_range(7) == 0);
      BranchRelEn = ($urandom_range(3) == 0);
      ALU_flag    = $urandom_range(1);
      StartAddr   = PC_W'($urandom);
      AbsTarget   = PC_W'($urandom);
      RelTarget   = REL_W'($urandom);
      applyStimulus("rand");
      if ($urandom_range(99) == 0) midCycleReset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
